instruction_fetch: RTL and testbench

IF stage and IF/ID pipeline register feeding the decode stage's pc/instr inputs.
- Owns the fetch PC and talks to instruction memory over a single-outstanding request/response interface with variable latency.
- Holds fetched instructions while decode stalls.
- Applies branch/jump redirects from decode after the architectural delay slot.

---
 rtl/instruction_fetch.sv | 145 ++++++++++++++
 tb/tb_instruction_fetch.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage plus IF/ID register: one outstanding imem request, a one-entry
// response buffer for decode stalls, and delay-slot aware branch redirects.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump_branch,
  input  logic        jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_id,
  output logic [31:0] instr_id,
  output logic        valid_id
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_redirect_pc;
  logic        r_redirect_pending;
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_instr;
  logic [31:0] r_pc_id;
  logic [31:0] r_instr_id;
  logic        r_valid_id;

  logic        w_load_id;
  logic        w_advance;
  logic        w_redirect_now;
  logic        w_fire;
  logic        w_buffer;
  logic [31:0] w_load_pc;
  logic [31:0] w_load_instr;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;
  logic [31:0] w_target;
  logic [31:0] w_next_pc;

  assign w_load_id = ~r_valid_id | ~stall;
  assign w_advance = r_valid_id & ~stall;

  // Redirect targets are relative to the instruction currently in ID.
  assign w_pc_plus4      = r_pc_id + 32'd4;
  assign w_branch_target = w_pc_plus4 + {{14{r_instr_id[15]}}, r_instr_id[15:0], 2'b00};
  assign w_jump_target   = {w_pc_plus4[31:28], r_instr_id[25:0], 2'b00};

  always_comb begin
    w_target = w_branch_target;
    if (jump_reg) begin
      w_target = jr_pc;
    end else if (jump_target) begin
      w_target = w_jump_target;
    end
  end

  assign w_redirect_now = w_advance & (jump_branch | jump_target | jump_reg);
  assign w_next_pc = w_redirect_now     ? w_target :
                     r_redirect_pending ? r_redirect_pc :
                                          r_fetch_pc + 32'd4;

  always_comb begin
    w_state_next = r_state;
    w_fire       = 1'b0;
    w_buffer     = 1'b0;
    w_load_pc    = r_buf_pc;
    w_load_instr = r_buf_instr;
    case (r_state)
      S_REQ: w_state_next = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          if (w_load_id) begin
            w_fire       = 1'b1;
            w_load_pc    = r_fetch_pc;
            w_load_instr = imem_rdata;
            w_state_next = S_REQ;
          end else begin
            w_buffer     = 1'b1;
            w_state_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_load_id) begin
          w_fire       = 1'b1;
          w_state_next = S_REQ;
        end
      end
      default: w_state_next = S_REQ;
    endcase
  end

  assign imem_req  = (r_state == S_REQ) & ~rst;
  assign imem_addr = imem_req ? r_fetch_pc : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= S_REQ;
      r_fetch_pc         <= RESET_PC;
      r_redirect_pc      <= 32'h0;
      r_redirect_pending <= 1'b0;
      r_buf_pc           <= 32'h0;
      r_buf_instr        <= 32'h0;
      r_pc_id            <= 32'h0;
      r_instr_id         <= 32'h0;
      r_valid_id         <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_buffer) begin
        r_buf_pc    <= r_fetch_pc;
        r_buf_instr <= imem_rdata;
      end
      if (w_fire) begin
        // The loading instruction is the delay slot of any earlier redirect.
        r_pc_id            <= w_load_pc;
        r_instr_id         <= w_load_instr;
        r_valid_id         <= 1'b1;
        r_fetch_pc         <= w_next_pc;
        r_redirect_pending <= 1'b0;
      end else begin
        if (w_advance) begin
          r_valid_id <= 1'b0;
          r_instr_id <= 32'h0;
        end
        if (w_redirect_now) begin
          r_redirect_pending <= 1'b1;
          r_redirect_pc      <= w_target;
        end
      end
    end
  end

  assign pc_id    = r_pc_id;
  assign instr_id = r_instr_id;
  assign valid_id = r_valid_id;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory responder, program-order reference
// model, directed vector table, hand-written corner sequences, random run.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, stall, jump_branch, jump_target, jump_reg;
  logic [31:0] jr_pc;
  logic        imem_req, imem_rvalid, valid_id;
  logic [31:0] imem_addr, imem_rdata, pc_id, instr_id;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .jump_branch(jump_branch), .jump_target(jump_target), .jump_reg(jump_reg),
    .jr_pc(jr_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_id(pc_id), .instr_id(instr_id), .valid_id(valid_id)
  );

  int total = 0;
  int bad = 0;

  // Program-order model: m_pc[n] is the n-th instruction address; m_taken/m_tgt
  // record the redirect decision made when instruction n left ID.
  logic [31:0] m_pc[$];
  bit          m_taken[$];
  logic [31:0] m_tgt[$];
  logic [31:0] fetch_log[$];
  logic [31:0] consume_log[$];
  int          fetch_cyc[$];
  logic [31:0] mem_over[logic [31:0]];

  int          cyc, req_cyc, cur_lat, fix_lat, stall_cnt, valid_cnt;
  bit          outstanding, rand_mode;
  logic [31:0] req_addr;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  bit          p_jb[8], p_jt[8], p_jr[8], p_sjb[8];
  logic [31:0] p_jrpc[8];
  int          p_stall[8];

  typedef struct {
    logic [31:0] p;
    logic [31:0] ins;
    bit          jb;
    bit          jt;
    bit          jr;
    logic [31:0] jrpc;
    int          lat;
    int          stl;
    bit          sjb;
    logic [31:0] exp_t;
    logic [31:0] exp_n;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_over.exists(a)) return mem_over[a];
    return (a * 32'h9E37_79B1) ^ 32'h2468_ACE1;
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] p, input logic [31:0] ins,
                                             input bit jb, input bit jt, input bit jr,
                                             input logic [31:0] jrpc);
    int imm;
    if (jr) return jrpc;
    if (jt) return ((p + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    imm = int'($signed(ins[15:0]));
    return p + 32'd4 + imm * 4;
  endfunction

  // Fetch n is the delay slot successor unless instruction n-2 redirected.
  function automatic logic [31:0] exp_fetch(input int n);
    if (n == 0) return RST_PC;
    if (n >= 2 && (n - 2) < m_taken.size() && m_taken[n-2]) return m_tgt[n-2];
    return m_pc[n-1] + 32'd4;
  endfunction

  task automatic clear_model();
    m_pc.delete(); m_taken.delete(); m_tgt.delete();
    fetch_log.delete(); consume_log.delete(); fetch_cyc.delete();
    outstanding = 0; cyc = 0; stall_cnt = 0; valid_cnt = 0;
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 8; i++) begin
      p_jb[i] = 0; p_jt[i] = 0; p_jr[i] = 0; p_sjb[i] = 0; p_jrpc[i] = 0; p_stall[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic sample();
    logic [31:0] e;
    s_req = imem_req; s_addr = imem_addr;
    s_valid = valid_id; s_pc = pc_id; s_instr = instr_id;
    if (s_valid) valid_cnt++;
    else chk("bubble_nop", s_instr, 32'h0);
    if (s_req) begin
      chk("single_outstanding", {31'h0, outstanding}, 32'h0);
      e = exp_fetch(fetch_log.size());
      chk("fetch_addr", s_addr, e);
      m_pc.push_back(e);
      fetch_log.push_back(s_addr);
      fetch_cyc.push_back(cyc);
      outstanding = 1;
      req_cyc = cyc;
      req_addr = s_addr;
      cur_lat = rand_mode ? int'($urandom_range(1, 4)) : fix_lat;
    end
  endtask

  task automatic drive();
    int idx;
    logic [31:0] p, ins;
    rst = 1'b0;
    imem_rvalid = outstanding && (cyc == req_cyc + cur_lat);
    imem_rdata = imem_rvalid ? mem_word(req_addr) : $urandom;
    if (imem_rvalid) outstanding = 0;
    idx = consume_log.size();
    stall = rand_mode ? ($urandom_range(0, 99) < 30) : (stall_cnt > 0);
    if (stall_cnt > 0) stall_cnt--;
    if (s_valid && idx < 8 && p_stall[idx] > 0) begin
      stall = 1'b1;
      p_stall[idx]--;
    end
    jump_branch = 0; jump_target = 0; jump_reg = 0; jr_pc = $urandom;
    if (stall) begin
      if (rand_mode) {jump_branch, jump_target, jump_reg} = 3'($urandom);
      else if (idx < 8) jump_branch = p_sjb[idx];
    end
    if (s_valid && !stall) begin
      if (idx >= m_pc.size()) begin
        chk("consume_order", idx, m_pc.size());
      end else begin
        p = m_pc[idx];
        ins = mem_word(p);
        chk("id_pc", s_pc, p);
        chk("id_instr", s_instr, ins);
        if (!rand_mode) begin
          if (idx < 8) begin
            jump_branch = p_jb[idx]; jump_target = p_jt[idx]; jump_reg = p_jr[idx];
            jr_pc = p_jrpc[idx];
          end
        end else if (!(idx > 0 && m_taken[idx-1]) && $urandom_range(0, 3) == 0) begin
          {jump_branch, jump_target, jump_reg} = 3'($urandom_range(1, 7));
          case ($urandom_range(0, 3))
            0:       jr_pc = 32'hFFFF_FFF8;
            1:       jr_pc = $urandom;
            default: jr_pc = $urandom & 32'h0003_FFFC;
          endcase
        end
        $display("id pc=%h instr=%h jb=%0d jt=%0d jr=%0d", s_pc, s_instr,
                 jump_branch, jump_target, jump_reg);
        consume_log.push_back(s_pc);
        m_taken.push_back(jump_branch | jump_target | jump_reg);
        m_tgt.push_back(ref_target(p, ins, jump_branch, jump_target, jump_reg, jr_pc));
      end
    end
  endtask

  task automatic run_cycle();
    tick();
    sample();
    drive();
  endtask

  task automatic do_reset();
    rst = 1; stall = 0; jump_branch = 0; jump_target = 0; jump_reg = 0;
    jr_pc = 0; imem_rvalid = 0; imem_rdata = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_req", {31'h0, imem_req}, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'h0, valid_id}, 32'h0);
      chk("rst_pc", pc_id, 32'h0);
      chk("rst_instr", instr_id, 32'h0);
    end
    rst = 0;
    clear_model();
    #1;
    sample();
    drive();
  endtask

  initial begin
    bit found;
    int n104;
    vecs[0]  = '{32'h200,       32'h1000_0010, 1, 0, 0, 32'h0,         2, 0, 0, 32'h244,       32'h248};
    vecs[1]  = '{32'h300,       32'h1000_FFFE, 1, 0, 0, 32'h0,         1, 0, 0, 32'h2FC,       32'h300};
    vecs[2]  = '{32'h400,       32'h0800_0040, 0, 1, 0, 32'h0,         1, 0, 0, 32'h100,       32'h104};
    vecs[3]  = '{32'h500,       32'h1000_0010, 1, 0, 1, 32'h1000,      1, 0, 0, 32'h1000,      32'h1004};
    vecs[4]  = '{32'h600,       32'h0800_0123, 1, 1, 0, 32'h0,         1, 0, 0, 32'h48C,       32'h490};
    vecs[5]  = '{32'h700,       32'h1000_0010, 0, 0, 1, 32'h2002,      3, 0, 0, 32'h2002,      32'h2006};
    vecs[6]  = '{32'h800,       32'h0000_0000, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 0, 32'hFFFF_FFFC, 32'h0};
    vecs[7]  = '{32'hA000_0000, 32'h0800_0010, 0, 1, 0, 32'h0,         1, 0, 0, 32'hA000_0040, 32'hA000_0044};
    vecs[8]  = '{32'h8,         32'h1000_FFF0, 1, 0, 0, 32'h0,         1, 0, 0, 32'hFFFF_FFCC, 32'hFFFF_FFD0};
    vecs[9]  = '{32'h900,       32'h1000_0008, 1, 0, 0, 32'h0,         1, 3, 0, 32'h924,       32'h928};
    vecs[10] = '{32'hA00,       32'h1000_0008, 0, 0, 0, 32'h0,         1, 2, 1, 32'hA08,       32'hA0C};
    vecs[11] = '{32'hB00,       32'h0800_0004, 0, 1, 0, 32'h0,         2, 4, 1, 32'h10,        32'h14};

    rand_mode = 0; fix_lat = 1; clear_plan(); clear_model();

    // Single-cycle memory: one instruction every two cycles.
    do_reset();
    for (int k = 0; k < 40 && consume_log.size() < 3; k++) run_cycle();
    chk("seq1_done", {31'h0, consume_log.size() >= 3}, 32'h1);
    if (consume_log.size() >= 3) begin
      chk("seq1_req_cyc0", fetch_cyc[0], 0);
      chk("seq1_req_cyc1", fetch_cyc[1], 2);
      chk("seq1_req_cyc2", fetch_cyc[2], 4);
      chk("seq1_pc0", consume_log[0], 32'h100);
      chk("seq1_pc1", consume_log[1], 32'h104);
      chk("seq1_pc2", consume_log[2], 32'h108);
      chk("seq1_valid_pulses", valid_cnt, 3);
    end

    // Three-cycle memory latency.
    fix_lat = 3;
    do_reset();
    for (int k = 0; k < 60 && consume_log.size() < 3; k++) run_cycle();
    chk("lat3_done", {31'h0, consume_log.size() >= 3}, 32'h1);
    if (consume_log.size() >= 3) begin
      chk("lat3_spacing1", fetch_cyc[1] - fetch_cyc[0], 4);
      chk("lat3_spacing2", fetch_cyc[2] - fetch_cyc[1], 4);
      chk("lat3_pc2", consume_log[2], 32'h108);
      chk("lat3_valid_pulses", valid_cnt, 3);
    end

    // Decode stall for four cycles while 0x108 returns into the buffer.
    fix_lat = 1;
    do_reset();
    found = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      sample();
      if (s_valid && s_pc == 32'h104) begin
        found = 1;
        break;
      end
      drive();
    end
    chk("stall_setup", {31'h0, found}, 32'h1);
    stall_cnt = 4;
    drive();
    for (int k = 0; k < 4; k++) begin
      tick();
      sample();
      chk("stall_hold_valid", {31'h0, s_valid}, 32'h1);
      chk("stall_hold_pc", s_pc, 32'h104);
      drive();
    end
    chk("stall_no_new_req", fetch_log.size(), 3);
    tick();
    sample();
    chk("stall_resume_valid", {31'h0, s_valid}, 32'h1);
    chk("stall_resume_pc", s_pc, 32'h108);
    drive();
    n104 = 0;
    foreach (consume_log[i]) if (consume_log[i] == 32'h104) n104++;
    chk("stall_no_dup", n104, 1);

    // Redirect vectors: jr from 0x100 to p, then the vector's branch at p.
    for (int v = 0; v < 12; v++) begin
      clear_plan();
      mem_over.delete();
      mem_over[vecs[v].p] = vecs[v].ins;
      p_jr[0] = 1; p_jrpc[0] = vecs[v].p;
      p_jb[2] = vecs[v].jb; p_jt[2] = vecs[v].jt; p_jr[2] = vecs[v].jr;
      p_jrpc[2] = vecs[v].jrpc; p_stall[2] = vecs[v].stl; p_sjb[2] = vecs[v].sjb;
      fix_lat = vecs[v].lat;
      do_reset();
      for (int k = 0; k < 300 && consume_log.size() < 6; k++) run_cycle();
      chk("vec_done", {31'h0, consume_log.size() >= 6}, 32'h1);
      if (consume_log.size() >= 6) begin
        chk("vec_branch_pc", fetch_log[2], vecs[v].p);
        chk("vec_delay_slot", fetch_log[3], vecs[v].p + 32'd4);
        chk("vec_target", fetch_log[4], vecs[v].exp_t);
        chk("vec_after_target", fetch_log[5], vecs[v].exp_n);
        chk("vec_id_target", consume_log[4], vecs[v].exp_t);
      end
      $display("vec %0d p=%h fetched target=%h", v, vecs[v].p,
               fetch_log.size() > 4 ? fetch_log[4] : 32'h0);
    end
    clear_plan();
    mem_over.delete();

    // Reset in WAIT with a redirect pending and a response due next cycle.
    fix_lat = 2;
    p_jr[0] = 1; p_jrpc[0] = 32'h5000;
    do_reset();
    for (int k = 0; k < 40 && fetch_log.size() < 2; k++) run_cycle();
    chk("rstwait_setup", fetch_log.size(), 2);
    clear_plan();
    tick();
    sample();
    rst = 1; stall = 0; imem_rvalid = 0;
    jump_branch = 0; jump_target = 0; jump_reg = 0;
    tick();
    rst = 0;
    clear_model();
    #1;
    chk("rstwait_valid", {31'h0, valid_id}, 32'h0);
    chk("rstwait_restart", imem_addr, RST_PC);
    sample();
    drive();
    imem_rvalid = 1;
    imem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 60 && consume_log.size() < 3; k++) run_cycle();
    chk("rstwait_done", {31'h0, consume_log.size() >= 3}, 32'h1);
    if (consume_log.size() >= 3) begin
      chk("rstwait_f1", fetch_log[1], 32'h104);
      chk("rstwait_f2", fetch_log[2], 32'h108);
    end

    // Random stalls, latencies and redirects against the model.
    rand_mode = 1;
    do_reset();
    for (int k = 0; k < 20000 && consume_log.size() < 300; k++) run_cycle();
    chk("random_progress", {31'h0, consume_log.size() >= 300}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
